// File: rtl/motion_frame_ctrl.sv
// Frame-level controller for the motion-detect compare stage.
// Pops background/current pixel pairs for one frame, applies the
// absolute-difference threshold compare, and pushes one motion bit per
// pixel through a single-entry holding register into the mask FIFO.
module motion_frame_ctrl #(
    parameter int         WIDTH      = 720,
    parameter int         HEIGHT     = 540,
    parameter int         CNT_W      = 20,
    parameter logic [7:0] THRESH_RST = 8'h32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_wr,
    input  logic [7:0]       cfg_thresh,
    output logic [7:0]       thresh,
    input  logic             bg_empty,
    output logic             bg_rd_en,
    input  logic [7:0]       bg_dout,
    input  logic             fr_empty,
    output logic             fr_rd_en,
    input  logic [7:0]       fr_dout,
    input  logic             out_full,
    output logic             out_wr_en,
    output logic             out_din,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] motion_count
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       thresh_q, thresh_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] run_motion_q, run_motion_d;
    logic [CNT_W-1:0] motion_count_q, motion_count_d;
    logic             hold_valid_q, hold_valid_d;
    logic             hold_bit_q, hold_bit_d;

    logic             abort_act;
    logic             pop;
    logic             push;
    logic             cmp_bit;

    // Larger minus smaller, so the result never wraps.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Strictly greater than threshold: diff == thresh is not motion.
    function automatic logic motion_bit(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] t);
        return abs_diff(a, b) > t;
    endfunction

    // Handshake decode: a pop needs both FIFOs non-empty and room in the
    // holding register (empty, or draining into the mask FIFO this cycle).
    // Abort suppresses both pop and push in the cycle it is seen.
    always_comb begin
        abort_act = abort & (state_q != S_IDLE);
        pop       = (state_q == S_RUN) & ~bg_empty & ~fr_empty
                    & (~hold_valid_q | ~out_full) & ~abort_act;
        push      = hold_valid_q & ~out_full & ~abort_act;
        cmp_bit   = motion_bit(bg_dout, fr_dout, thresh_q);
    end

    // Next-state, counter and holding-register update.
    always_comb begin
        state_d        = state_q;
        thresh_d       = thresh_q;
        pix_cnt_d      = pix_cnt_q;
        run_motion_d   = run_motion_q;
        motion_count_d = motion_count_q;
        hold_valid_d   = hold_valid_q;
        hold_bit_d     = hold_bit_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_wr) begin
                    thresh_d = cfg_thresh;
                end
                if (start) begin
                    state_d      = S_RUN;
                    pix_cnt_d    = '0;
                    run_motion_d = '0;
                end
            end
            S_RUN: begin
                if (pop) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (cmp_bit) begin
                        run_motion_d = run_motion_q + 1'b1;
                    end
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!hold_valid_q || push) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                motion_count_d = run_motion_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A pop refills the holding register even while it drains.
        if (pop) begin
            hold_valid_d = 1'b1;
            hold_bit_d   = cmp_bit;
        end else if (push) begin
            hold_valid_d = 1'b0;
        end

        // Abort flushes to IDLE, drops the held bit and keeps the last
        // completed frame's motion count.
        if (abort_act) begin
            state_d        = S_IDLE;
            hold_valid_d   = 1'b0;
            motion_count_d = motion_count_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            thresh_q       <= THRESH_RST;
            pix_cnt_q      <= '0;
            run_motion_q   <= '0;
            motion_count_q <= '0;
            hold_valid_q   <= 1'b0;
            hold_bit_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            thresh_q       <= thresh_d;
            pix_cnt_q      <= pix_cnt_d;
            run_motion_q   <= run_motion_d;
            motion_count_q <= motion_count_d;
            hold_valid_q   <= hold_valid_d;
            hold_bit_q     <= hold_bit_d;
        end
    end

    assign thresh       = thresh_q;
    assign bg_rd_en     = pop;
    assign fr_rd_en     = pop;
    assign out_wr_en    = push;
    assign out_din      = hold_bit_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE) && !abort_act;
    assign motion_count = motion_count_q;

endmodule

// File: tb/tb_motion_frame_ctrl.sv
// Scoreboard bench for motion_frame_ctrl on a 4x2 frame.
module tb_motion_frame_ctrl;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [7:0]       cfg_thresh = 8'd0;
    logic [7:0]       thresh;
    logic             bg_empty, bg_rd_en;
    logic [7:0]       bg_dout;
    logic             fr_empty, fr_rd_en;
    logic [7:0]       fr_dout;
    logic             out_full = 1'b0;
    logic             out_wr_en, out_din;
    logic             busy, done;
    logic [CNT_W-1:0] motion_count;

    motion_frame_ctrl #(
        .WIDTH(4), .HEIGHT(2), .CNT_W(CNT_W), .THRESH_RST(8'h32)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .cfg_wr(cfg_wr), .cfg_thresh(cfg_thresh), .thresh(thresh),
        .bg_empty(bg_empty), .bg_rd_en(bg_rd_en), .bg_dout(bg_dout),
        .fr_empty(fr_empty), .fr_rd_en(fr_rd_en), .fr_dout(fr_dout),
        .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
        .busy(busy), .done(done), .motion_count(motion_count)
    );

    always #5 clock = ~clock;

    // First-word-fall-through FIFO models
    logic [7:0] bg_mem [0:15];
    logic [7:0] fr_mem [0:15];
    int         bg_len = 0, fr_len = 0;
    logic [4:0] bg_ptr = 5'd0, fr_ptr = 5'd0;
    logic       flush = 1'b0;
    logic       fr_stall = 1'b0;

    assign bg_empty = (int'(bg_ptr) >= bg_len);
    assign fr_empty = fr_stall || (int'(fr_ptr) >= fr_len);
    assign bg_dout  = bg_mem[bg_ptr[3:0]];
    assign fr_dout  = fr_mem[fr_ptr[3:0]];

    always @(posedge clock) begin
        if (flush) begin
            bg_ptr <= 5'd0;
            fr_ptr <= 5'd0;
        end else begin
            if (bg_rd_en) bg_ptr <= bg_ptr + 5'd1;
            if (fr_rd_en) fr_ptr <= fr_ptr + 5'd1;
        end
    end

    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   pop_cnt = 0, push_cnt = 0, done_cnt = 0;
    int   last_push_cyc = 0, done_cyc = 0;
    logic exp_q[$];
    logic mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every push against the scoreboard queue
    always @(negedge clock) begin
        check("rd_en_match", int'(bg_rd_en), int'(fr_rd_en));
        if (bg_rd_en) begin
            check("pop_when_empty", int'(bg_empty | fr_empty), 0);
            pop_cnt++;
        end
        if (out_wr_en) begin
            check("push_when_full", int'(out_full), 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_push: got out_din=%0d, required no push (cycle %0d)",
                         out_din, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("mask_bit", int'(out_din), int'(mon_e));
            end
            push_cnt++;
            last_push_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Load both FIFO models and push the expected mask bits (pixel 0 first).
    task automatic load_frame(input logic [63:0] bgv, input logic [63:0] frv,
                              input int nbg, input int nfr,
                              input logic [7:0] expv, input int nexp);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bg_mem[i] = bgv[63-8*i -: 8];
            fr_mem[i] = frv[63-8*i -: 8];
        end
        bg_len = nbg;
        fr_len = nfr;
        for (int i = 0; i < nexp; i++) exp_q.push_back(expv[7-i]);
    endtask

    // Start one frame and run it to the done pulse, with optional stress.
    task automatic run_frame(input bit tog, input int emp_at, input int emp_len,
                             input bit cfg_mid, input bit start_mid,
                             input int exp_count);
        int d0, p0;
        d0 = done_cnt;
        p0 = push_cnt;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && done_cnt == d0; i++) begin
            out_full   = tog ? ~out_full : 1'b0;
            fr_stall   = (i >= emp_at) && (i < emp_at + emp_len);
            cfg_wr     = cfg_mid && (i == 2);
            cfg_thresh = cfg_wr ? 8'd255 : 8'd0;
            start      = start_mid && (i == 3);
            @(posedge clock); #1;
        end
        out_full = 1'b0; fr_stall = 1'b0; cfg_wr = 1'b0; start = 1'b0;
        check("frame_done_seen", int'(done_cnt != d0), 1);
        check("done_after_last_push", done_cyc, last_push_cyc + 1);
        check("push_count", push_cnt - p0, 8);
        check("motion_count", int'(motion_count), exp_count);
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(posedge clock);
        #1;
        check("single_done_pulse", done_cnt - d0, 1);
        check("idle_after_frame", int'(busy), 0);
    endtask

    localparam logic [63:0] F1_BG = {8{8'd100}};
    localparam logic [63:0] F1_FR = {8'd100, 8'd150, 8'd151, 8'd49,
                                     8'd50, 8'd200, 8'd0, 8'd255};
    localparam logic [63:0] F4_BG = {8{8'd7}};
    localparam logic [63:0] F4_FR = {8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd8, 8'd7, 8'd7};

    initial begin
        int p0, q0, d0;
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_thresh", int'(thresh), 32'h32);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        check("rst_motion_count", int'(motion_count), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("idle_rd_en", int'(bg_rd_en), 0);

        // Basic frame, threshold 50
        load_frame(F1_BG, F1_FR, 8, 8, 8'b00110111, 8);
        run_frame(1'b0, 0, 0, 1'b0, 1'b0, 5);

        // Same frame with back-pressure toggling and a start while busy
        load_frame(F1_BG, F1_FR, 8, 8, 8'b00110111, 8);
        run_frame(1'b1, 0, 0, 1'b0, 1'b1, 5);

        // Current-frame FIFO empty for 3 cycles mid-frame
        load_frame(F1_BG, F1_FR, 8, 8, 8'b00110111, 8);
        run_frame(1'b0, 2, 3, 1'b0, 1'b0, 5);

        // Threshold 0, single differing pixel; write during RUN ignored
        cfg_wr = 1'b1; cfg_thresh = 8'd0;
        @(posedge clock); #1;
        cfg_wr = 1'b0;
        check("cfg_thresh_zero", int'(thresh), 0);
        load_frame(F4_BG, F4_FR, 8, 8, 8'b00000100, 8);
        run_frame(1'b0, 0, 0, 1'b1, 1'b0, 1);
        check("thresh_after_run_write", int'(thresh), 0);

        // Abort after 3 pops (only 3 current pixels available)
        load_frame(F1_BG, F1_FR, 8, 3, 8'b01100000, 3);
        p0 = pop_cnt; q0 = push_cnt; d0 = done_cnt;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("abort_pops_before", pop_cnt - p0, 3);
        check("abort_pushes_before", push_cnt - q0, 3);
        check("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_busy_after", int'(busy), 0);
        check("abort_wr_en_after", int'(out_wr_en), 0);
        repeat (2) @(posedge clock);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_motion_count_kept", int'(motion_count), 1);
        check("abort_scoreboard", exp_q.size(), 0);
        load_frame(F1_BG, F1_FR, 8, 8, 8'b01111111, 8);
        run_frame(1'b0, 0, 0, 1'b0, 1'b0, 7);

        // Asynchronous reset while a bit is held under back-pressure
        load_frame(F1_BG, F1_FR, 8, 8, 8'b00000000, 0);
        out_full = 1'b1;
        p0 = pop_cnt; q0 = push_cnt;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("hold_single_pop", pop_cnt - p0, 1);
        check("hold_thresh_before_reset", int'(thresh), 0);
        reset = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_wr_en", int'(out_wr_en), 0);
        check("midrst_rd_en", int'(bg_rd_en), 0);
        check("midrst_out_din", int'(out_din), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_thresh", int'(thresh), 32'h32);
        check("midrst_motion_count", int'(motion_count), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        out_full = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("no_push_after_reset", push_cnt - q0, 0);
        check("idle_after_reset", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
